// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch button path: FSM encoding and
// elaboration-time helpers for counter and divider sizing.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ARM     = 2'd0,
      IDLE    = 2'd1,
      PRESSED = 2'd2,
      LONG    = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int div_of(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Restartable tick divider: a synchronous clear lets the caller align
// ticks exactly to an event edge, unlike a free-running divider.
module tick_gen
   import stopwatch_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int W = clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] count_r;

   // Divider count: clear, wrap at DIV-1, otherwise increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {W{1'b0}};
      end else if (clr) begin
         count_r <= {W{1'b0}};
      end else if (count_r == LAST) begin
         count_r <= {W{1'b0}};
      end else begin
         count_r <= count_r + W'(1);
      end
   end

   assign tick = (count_r == LAST);

endmodule

// File: rtl/button_event_decoder.sv
// Turns the debounced button level into single-cycle press, short, long,
// repeat and release events, timed from the press edge.
module button_event_decoder
   import stopwatch_pkg::*;
#(
   parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
   parameter int TICK_RATE_HZ                = 1000,
   parameter int LONG_PRESS_TICKS            = 1000,
   parameter int REPEAT_TICKS                = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic press_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic release_pulse,
   output logic held
);

   localparam int DIV   = div_of(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_RATE_HZ);
   localparam int CNT_W = clog2(max_of(LONG_PRESS_TICKS, REPEAT_TICKS) + 1);
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_TICKS);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS);
   localparam bit REPEAT_EN = (REPEAT_TICKS != 0);

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             clr_s, tick_s;
   logic             press_s, short_s, long_s, repeat_s, release_s, held_s;
   logic             press_r, short_r, long_r, repeat_r, release_r, held_r;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_s),
      .tick (tick_s)
   );

   // Next-state, tick counting and event decode; release beats a coincident tick.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      clr_s     = 1'b0;
      press_s   = 1'b0;
      short_s   = 1'b0;
      long_s    = 1'b0;
      repeat_s  = 1'b0;
      release_s = 1'b0;
      case (state_r)
         ARM: begin
            if (!btn_in) state_s = IDLE;
            else         state_s = ARM;
         end
         IDLE: begin
            if (btn_in) begin
               state_s = PRESSED;
               press_s = 1'b1;
               clr_s   = 1'b1;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         PRESSED: begin
            if (!btn_in) begin
               state_s   = IDLE;
               short_s   = 1'b1;
               release_s = 1'b1;
            end else if (tick_s) begin
               if ((cnt_r + CNT_W'(1)) == LONG_LAST) begin
                  state_s = LONG;
                  long_s  = 1'b1;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         LONG: begin
            if (!btn_in) begin
               state_s   = IDLE;
               release_s = 1'b1;
            end else if (tick_s && REPEAT_EN) begin
               if ((cnt_r + CNT_W'(1)) == REPEAT_LAST) begin
                  repeat_s = 1'b1;
                  cnt_s    = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s = ARM;
         end
      endcase
      held_s = (state_s == PRESSED) || (state_s == LONG);
   end

   // State, counter and registered event outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ARM;
         cnt_r     <= {CNT_W{1'b0}};
         press_r   <= 1'b0;
         short_r   <= 1'b0;
         long_r    <= 1'b0;
         repeat_r  <= 1'b0;
         release_r <= 1'b0;
         held_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         press_r   <= press_s;
         short_r   <= short_s;
         long_r    <= long_s;
         repeat_r  <= repeat_s;
         release_r <= release_s;
         held_r    <= held_s;
      end
   end

   assign press_pulse   = press_r;
   assign short_pulse   = short_r;
   assign long_pulse    = long_r;
   assign repeat_pulse  = repeat_r;
   assign release_pulse = release_r;
   assign held          = held_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: directed scenarios plus
// random hold/gap patterns against an elapsed-time reference model.
module tb_button_event_decoder;

   localparam int FREQ = 1000;
   localparam int RATE = 100;
   localparam int DIV  = 10;
   localparam int LT   = 5;
   localparam int RT   = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_in = 1'b0;
   logic press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held;

   int checks = 0;
   int errors = 0;

   // Reference model: locked after reset until btn low, then press time based.
   bit       locked = 1'b1;
   bit       pressing = 1'b0;
   int       press_cyc = 0;
   int       tcyc = 0;
   logic [5:0] exp_v = 6'd0;   // {press, short, long, repeat, release, held}
   logic [5:0] obs;

   button_event_decoder #(
      .BOARD_CLOCK_FREQUENCY_IN_HZ(FREQ),
      .TICK_RATE_HZ(RATE),
      .LONG_PRESS_TICKS(LT),
      .REPEAT_TICKS(RT)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in),
      .press_pulse(press_pulse), .short_pulse(short_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
      .release_pulse(release_pulse), .held(held)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      locked   = 1'b1;
      pressing = 1'b0;
      exp_v    = 6'd0;
   endtask

   // Drive btn for the current cycle and predict the outputs of the next one.
   task automatic drive(input logic b);
      int d;
      int n;
      logic [5:0] e;
      btn_in = b;
      e = 6'd0;
      if (locked) begin
         if (!b) locked = 1'b0;
      end else if (!pressing) begin
         if (b) begin
            e[5] = 1'b1;
            pressing = 1'b1;
            press_cyc = tcyc;
         end
      end else begin
         d = tcyc - press_cyc;
         if (!b) begin
            e[1] = 1'b1;
            e[4] = (d <= LT * DIV);
            pressing = 1'b0;
         end else if (d % DIV == 0) begin
            n = d / DIV;
            if (n == LT) e[3] = 1'b1;
            else if (n > LT && RT != 0 && (n - LT) % RT == 0) e[2] = 1'b1;
         end
      end
      e[0] = pressing;
      exp_v = e;
      tcyc++;
   endtask

   task automatic test_reset();
      btn_in = 1'b1;
      #2 rst = 1'b1;
      #1;
      checks++;
      obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
      if (obs !== 6'd0) begin
         $display("FAIL reset_async got %b exp %b", obs, 6'd0);
         errors++;
      end
      model_reset();
   endtask

   task automatic test_reset_lockout();
      int first_press;
      first_press = -1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive(1'b1);
      for (int i = 0; i < 140; i++) begin
         @(negedge clk);
         obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
         checks++;
         if (obs !== exp_v) begin
            $display("FAIL lockout cycle %0d got %b exp %b", i, obs, exp_v);
            errors++;
         end
         if (press_pulse && first_press < 0) first_press = i;
         drive((i < 100) ? 1'b1 : (i < 110) ? 1'b0 : (i < 130) ? 1'b1 : 1'b0);
      end
      checks++;
      if (first_press !== 111) begin
         $display("FAIL lockout_press_cycle got %0d exp %0d", first_press, 111);
         errors++;
      end
   endtask

   task automatic test_short_press();
      int first_short, held_cnt, n_long;
      first_short = -1; held_cnt = 0; n_long = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
         checks++;
         if (obs !== exp_v) begin
            $display("FAIL short cycle %0d got %b exp %b", i, obs, exp_v);
            errors++;
         end
         if (short_pulse && release_pulse && first_short < 0) first_short = i;
         if (held) held_cnt++;
         if (long_pulse) n_long++;
         drive((i < 30) ? 1'b1 : 1'b0);
      end
      checks++;
      if (first_short !== 31 || held_cnt !== 30 || n_long !== 0) begin
         $display("FAIL short_timing got short@%0d held=%0d long=%0d exp short@31 held=30 long=0",
                  first_short, held_cnt, n_long);
         errors++;
      end
   endtask

   task automatic test_long_repeat();
      int long_at, rep1, rep2, n_rep, rel_at, n_short;
      long_at = -1; rep1 = -1; rep2 = -1; n_rep = 0; rel_at = -1; n_short = 0;
      for (int i = 0; i < 115; i++) begin
         @(negedge clk);
         obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
         checks++;
         if (obs !== exp_v) begin
            $display("FAIL long cycle %0d got %b exp %b", i, obs, exp_v);
            errors++;
         end
         if (long_pulse) long_at = i;
         if (repeat_pulse) begin
            n_rep++;
            if (rep1 < 0) rep1 = i; else rep2 = i;
         end
         if (release_pulse) rel_at = i;
         if (short_pulse) n_short++;
         drive((i < 100) ? 1'b1 : 1'b0);
      end
      checks++;
      if (long_at !== 51 || rep1 !== 71 || rep2 !== 91 || n_rep !== 2 || rel_at !== 101 || n_short !== 0) begin
         $display("FAIL long_timing got long@%0d rep@%0d,%0d n=%0d rel@%0d short=%0d exp 51 71,91 2 101 0",
                  long_at, rep1, rep2, n_rep, rel_at, n_short);
         errors++;
      end
   endtask

   task automatic test_threshold(input int rel_cycle, input int exp_long, input int exp_rel,
                                 input int exp_short);
      int long_at, rel_at, short_at;
      long_at = -1; rel_at = -1; short_at = -1;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
         checks++;
         if (obs !== exp_v) begin
            $display("FAIL threshold%0d cycle %0d got %b exp %b", rel_cycle, i, obs, exp_v);
            errors++;
         end
         if (long_pulse) long_at = i;
         if (release_pulse) rel_at = i;
         if (short_pulse) short_at = i;
         drive((i < rel_cycle) ? 1'b1 : 1'b0);
      end
      checks++;
      if (long_at !== exp_long || rel_at !== exp_rel || short_at !== exp_short) begin
         $display("FAIL threshold%0d_timing got long@%0d rel@%0d short@%0d exp %0d %0d %0d",
                  rel_cycle, long_at, rel_at, short_at, exp_long, exp_rel, exp_short);
         errors++;
      end
   endtask

   task automatic test_async_reset_long();
      int first_press, early;
      first_press = -1; early = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
         checks++;
         if (obs !== exp_v) begin
            $display("FAIL pre_reset cycle %0d got %b exp %b", i, obs, exp_v);
            errors++;
         end
         drive(1'b1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (held !== 1'b1) begin
         $display("FAIL held_before_reset got %b exp %b", held, 1'b1);
         errors++;
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
      if (obs !== 6'd0) begin
         $display("FAIL reset_mid_long got %b exp %b", obs, 6'd0);
         errors++;
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
         checks++;
         if (obs !== exp_v) begin
            $display("FAIL post_reset cycle %0d got %b exp %b", i, obs, exp_v);
            errors++;
         end
         if (i < 36 && obs !== 6'd0) early++;
         if (press_pulse && first_press < 0) first_press = i;
         drive((i < 30) ? 1'b1 : (i < 35) ? 1'b0 : (i < 45) ? 1'b1 : 1'b0);
      end
      checks++;
      if (first_press !== 36 || early !== 0) begin
         $display("FAIL post_reset_lockout got press@%0d early=%0d exp press@36 early=0",
                  first_press, early);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      int short_at, press2_at, long_at;
      short_at = -1; press2_at = -1; long_at = -1;
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
         checks++;
         if (obs !== exp_v) begin
            $display("FAIL b2b cycle %0d got %b exp %b", i, obs, exp_v);
            errors++;
         end
         if (short_pulse && release_pulse) short_at = i;
         if (press_pulse && i > 1) press2_at = i;
         if (long_pulse && long_at < 0) long_at = i;
         drive((i == 30 || i >= 95) ? 1'b0 : 1'b1);
      end
      checks++;
      if (short_at !== 31 || press2_at !== 32 || long_at !== 82) begin
         $display("FAIL b2b_timing got short@%0d press@%0d long@%0d exp 31 32 82",
                  short_at, press2_at, long_at);
         errors++;
      end
   endtask

   task automatic test_random();
      int remaining;
      logic level;
      remaining = 5;
      level = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         obs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
         checks++;
         if (obs !== exp_v) begin
            $display("FAIL random cycle %0d got %b exp %b", i, obs, exp_v);
            errors++;
         end
         if (remaining == 0) begin
            level = ~level;
            if (!level) remaining = int'($urandom_range(12, 1));
            else if ($urandom_range(3, 0) == 0) remaining = int'($urandom_range(52, 48));
            else remaining = int'($urandom_range(110, 1));
         end
         remaining--;
         drive(level);
      end
   endtask

   initial begin
      test_reset();
      test_reset_lockout();
      test_short_press();
      test_long_repeat();
      test_threshold(50, -1, 51, 51);
      test_threshold(51, 51, 52, -1);
      test_async_reset_long();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
